// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised, OVERSAMPLE-times oversampled 8N1-style
// decoder with 3-sample majority vote at each bit centre, a one-entry holding
// register, and framing / overrun flags.
//
// Handshake (holding register): dataReadyOUT is "valid", readIN is "ready".
// A byte transfers to the consumer on any clock edge where both are high;
// readIN while dataReadyOUT is low does nothing. dataOUT stays stable from
// one load until the next load, independent of reads.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int MID        = OVERSAMPLE / 2
) (
    input  logic                 baudClkX16,
    input  logic                 nResetIN,
    input  logic                 rxIN,
    input  logic                 readIN,
    output logic [DATA_BITS-1:0] dataOUT,
    output logic                 dataReadyOUT,
    output logic                 frameErrOUT,
    output logic                 overrunOUT,
    output logic                 nBusyOUT,
    output logic [2:0]           stateDbgOUT
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t               state;
    logic                 rxMeta;
    logic                 rxS;
    logic                 rxP;
    logic                 rxPP;
    logic                 vote;
    logic [CNT_W-1:0]     sampleCnt;
    logic [BIT_W-1:0]     bitCnt;
    logic [DATA_BITS-1:0] shiftReg;

    assign stateDbgOUT = state;

    // Majority of the three most recent synchronised samples; only looked at
    // when sampleCnt is MID, so it covers counts MID-2, MID-1 and MID.
    assign vote = (rxS & rxP) | (rxS & rxPP) | (rxP & rxPP);

    // Synchronizer and sample history; preset high so reset release looks idle.
    always_ff @(posedge baudClkX16 or negedge nResetIN) begin
        if (!nResetIN) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
            rxP    <= 1'b1;
            rxPP   <= 1'b1;
        end else begin
            rxMeta <= rxIN;
            rxS    <= rxMeta;
            rxP    <= rxS;
            rxPP   <= rxP;
        end
    end

    // Frame state machine, holding register and status flags.
    always_ff @(posedge baudClkX16 or negedge nResetIN) begin
        if (!nResetIN) begin
            state        <= IDLE;
            sampleCnt    <= '0;
            bitCnt       <= '0;
            shiftReg     <= '0;
            dataOUT      <= '0;
            dataReadyOUT <= 1'b0;
            frameErrOUT  <= 1'b0;
            overrunOUT   <= 1'b0;
            nBusyOUT     <= 1'b1;
        end else begin
            // Free-running within a frame; power-of-two width wraps by itself.
            sampleCnt <= sampleCnt + CNT_W'(1);

            // Consumer pop; a load later in this block takes precedence.
            if (readIN && dataReadyOUT) begin
                dataReadyOUT <= 1'b0;
                frameErrOUT  <= 1'b0;
                overrunOUT   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    nBusyOUT <= 1'b1;
                    if (rxP && !rxS) begin
                        state     <= START;
                        sampleCnt <= '0;
                        nBusyOUT  <= 1'b0;
                    end
                end
                START: begin
                    if (sampleCnt == CNT_MID && vote) begin
                        // Line was back high at the start-bit centre: a glitch.
                        state    <= IDLE;
                        nBusyOUT <= 1'b1;
                    end else if (sampleCnt == CNT_LAST) begin
                        state  <= DATA;
                        bitCnt <= '0;
                    end
                end
                DATA: begin
                    if (sampleCnt == CNT_MID) begin
                        shiftReg <= {vote, shiftReg[DATA_BITS-1:1]};
                    end
                    if (sampleCnt == CNT_LAST) begin
                        if (bitCnt == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bitCnt <= bitCnt + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (sampleCnt == CNT_MID) begin
                        dataOUT      <= shiftReg;
                        dataReadyOUT <= 1'b1;
                        frameErrOUT  <= ~vote;
                        // Overwriting an unread byte; a same-cycle read is not an overrun.
                        if (dataReadyOUT && !readIN) begin
                            overrunOUT <= 1'b1;
                        end
                        // Leaving at mid-stop lets an early next start edge be caught.
                        state    <= vote ? IDLE : BREAK;
                        nBusyOUT <= vote;
                    end
                end
                BREAK: begin
                    // A line held low must go high before another start is accepted.
                    if (rxS) begin
                        state    <= IDLE;
                        nBusyOUT <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    nBusyOUT <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: frames are driven bit by bit with a chosen
// number of clocks per bit; expected bytes, flags and cycle positions are
// hand-derived from the frame timing.
module tb_uart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int MID        = OVERSAMPLE / 2;
    // Edges from the start-detect edge E to the load edge.
    localparam int LAT        = OVERSAMPLE * (1 + DATA_BITS) + MID + 1;
    // rxIN driven just after edge m is seen as a falling edge at E = m + 3.
    localparam int SYNC_DLY   = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic                 baudClkX16 = 1'b0;
    logic                 nResetIN   = 1'b0;
    logic                 rxIN       = 1'b1;
    logic                 readIN     = 1'b0;
    logic [DATA_BITS-1:0] dataOUT;
    logic                 dataReadyOUT;
    logic                 frameErrOUT;
    logic                 overrunOUT;
    logic                 nBusyOUT;
    logic [2:0]           stateDbgOUT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .MID       (MID)
    ) dut (
        .baudClkX16  (baudClkX16),
        .nResetIN    (nResetIN),
        .rxIN        (rxIN),
        .readIN      (readIN),
        .dataOUT     (dataOUT),
        .dataReadyOUT(dataReadyOUT),
        .frameErrOUT (frameErrOUT),
        .overrunOUT  (overrunOUT),
        .nBusyOUT    (nBusyOUT),
        .stateDbgOUT (stateDbgOUT)
    );

    // Clock and edge counter
    always #5 baudClkX16 = ~baudClkX16;

    always @(posedge baudClkX16) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Move to 1 time unit after the next rising edge.
    task automatic align();
        @(posedge baudClkX16);
        #1;
    endtask

    // Advance until the counter has reached edge t, settling 1 unit after it.
    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge baudClkX16);
            #1;
        end
    endtask

    // Drive start, data (LSB first) and stop; even/odd bit slots get pEven/pOdd clocks.
    // Called 1 unit after an edge. A zero stop bit leaves the line low afterwards.
    task automatic send_frame(input logic [7:0] d, input int pEven, input int pOdd,
                              input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxIN = bits[k];
            repeat ((k % 2 == 0) ? pEven : pOdd) @(posedge baudClkX16);
            #1;
        end
    endtask

    task automatic do_read();
        readIN = 1'b1;
        @(posedge baudClkX16);
        #1;
        readIN = 1'b0;
    endtask

    task automatic test_reset();
        nResetIN = 1'b0;
        #23;
        checks++; if (dataOUT !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", dataOUT); end
        checks++; if (dataReadyOUT !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", dataReadyOUT); end
        checks++; if (frameErrOUT !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", frameErrOUT); end
        checks++; if (overrunOUT !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", overrunOUT); end
        checks++; if (nBusyOUT !== 1'b1) begin errors++; $display("FAIL rst_nbusy: got %b want 1", nBusyOUT); end
        checks++; if (stateDbgOUT !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", stateDbgOUT, ST_IDLE); end
        align();
        nResetIN = 1'b1;
        repeat (5) align();
        checks++; if (nBusyOUT !== 1'b1 || stateDbgOUT !== ST_IDLE) begin errors++; $display("FAIL rst_release: nbusy %b state %0d want 1/%0d", nBusyOUT, stateDbgOUT, ST_IDLE); end
    endtask

    task automatic test_nominal();
        int e;
        align();
        e = cyc + SYNC_DLY;
        fork
            send_frame(8'hA5, 16, 16, 1'b1);
            begin
                wait_cyc(e + 1);
                checks++; if (nBusyOUT !== 1'b0) begin errors++; $display("FAIL nom_busy_first: got %b want 0", nBusyOUT); end
                wait_cyc(e + LAT - 1);
                checks++; if (nBusyOUT !== 1'b0) begin errors++; $display("FAIL nom_busy_last: got %b want 0", nBusyOUT); end
                checks++; if (dataReadyOUT !== 1'b0) begin errors++; $display("FAIL nom_ready_early: got %b want 0", dataReadyOUT); end
                wait_cyc(e + LAT);
                checks++; if (dataReadyOUT !== 1'b1) begin errors++; $display("FAIL nom_ready: got %b want 1", dataReadyOUT); end
                checks++; if (dataOUT !== 8'hA5) begin errors++; $display("FAIL nom_data: got %h want a5", dataOUT); end
                checks++; if (frameErrOUT !== 1'b0 || overrunOUT !== 1'b0) begin errors++; $display("FAIL nom_flags: ferr %b ovr %b want 0/0", frameErrOUT, overrunOUT); end
                checks++; if (nBusyOUT !== 1'b1) begin errors++; $display("FAIL nom_busy_end: got %b want 1", nBusyOUT); end
            end
        join
        do_read();
        checks++; if (dataReadyOUT !== 1'b0) begin errors++; $display("FAIL nom_read: ready %b want 0", dataReadyOUT); end
        do_read();
        checks++; if (dataOUT !== 8'hA5 || dataReadyOUT !== 1'b0) begin errors++; $display("FAIL nom_read_empty: data %h ready %b want a5/0", dataOUT, dataReadyOUT); end
    endtask

    task automatic test_glitch();
        int m;
        align();
        m = cyc;
        rxIN = 1'b0;
        repeat (4) @(posedge baudClkX16);
        #1;
        rxIN = 1'b1;
        wait_cyc(m + 5);
        checks++; if (nBusyOUT !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", nBusyOUT); end
        wait_cyc(m + 4 + OVERSAMPLE / 2 + 3);
        checks++; if (nBusyOUT !== 1'b1 || stateDbgOUT !== ST_IDLE) begin errors++; $display("FAIL glitch_idle: nbusy %b state %0d want 1/%0d", nBusyOUT, stateDbgOUT, ST_IDLE); end
        wait_cyc(m + 200);
        checks++; if (dataReadyOUT !== 1'b0) begin errors++; $display("FAIL glitch_ready: got %b want 0", dataReadyOUT); end
    endtask

    task automatic test_framing();
        int m;
        int bad;
        int r;
        align();
        m = cyc;
        send_frame(8'h3C, 16, 16, 1'b0);
        wait_cyc(m + SYNC_DLY + LAT);
        checks++; if (dataOUT !== 8'h3C || dataReadyOUT !== 1'b1) begin errors++; $display("FAIL frm_data: data %h ready %b want 3c/1", dataOUT, dataReadyOUT); end
        checks++; if (frameErrOUT !== 1'b1) begin errors++; $display("FAIL frm_ferr: got %b want 1", frameErrOUT); end
        checks++; if (stateDbgOUT !== ST_BREAK || nBusyOUT !== 1'b0) begin errors++; $display("FAIL frm_break: state %0d nbusy %b want %0d/0", stateDbgOUT, nBusyOUT, ST_BREAK); end
        bad = 0;
        for (int i = 0; i < 40 * OVERSAMPLE; i++) begin
            align();
            if (stateDbgOUT !== ST_BREAK || nBusyOUT !== 1'b0 || overrunOUT !== 1'b0 ||
                dataOUT !== 8'h3C || dataReadyOUT !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL frm_hold_low: %0d bad cycles want 0", bad); end
        rxIN = 1'b1;
        r = cyc;
        wait_cyc(r + 4);
        checks++; if (stateDbgOUT !== ST_IDLE || nBusyOUT !== 1'b1) begin errors++; $display("FAIL frm_release: state %0d nbusy %b want %0d/1", stateDbgOUT, nBusyOUT, ST_IDLE); end
        do_read();
        checks++; if (frameErrOUT !== 1'b0 || dataReadyOUT !== 1'b0) begin errors++; $display("FAIL frm_read: ferr %b ready %b want 0/0", frameErrOUT, dataReadyOUT); end
    endtask

    task automatic test_overrun();
        int m;
        align();
        m = cyc;
        send_frame(8'h11, 16, 16, 1'b1);
        send_frame(8'h22, 16, 16, 1'b1);
        wait_cyc(m + 160 + SYNC_DLY + LAT);
        checks++; if (dataOUT !== 8'h22 || dataReadyOUT !== 1'b1) begin errors++; $display("FAIL ovr_data: data %h ready %b want 22/1", dataOUT, dataReadyOUT); end
        checks++; if (overrunOUT !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrunOUT); end
        align();
        m = cyc;
        fork
            send_frame(8'h33, 16, 16, 1'b1);
            begin
                wait_cyc(m + SYNC_DLY + LAT - 1);
                readIN = 1'b1;
                wait_cyc(m + SYNC_DLY + LAT);
                readIN = 1'b0;
                checks++; if (dataOUT !== 8'h33 || dataReadyOUT !== 1'b1) begin errors++; $display("FAIL ovr_same_cycle: data %h ready %b want 33/1", dataOUT, dataReadyOUT); end
                checks++; if (overrunOUT !== 1'b0) begin errors++; $display("FAIL ovr_same_cycle_flag: got %b want 0", overrunOUT); end
            end
        join
        do_read();
        checks++; if (dataReadyOUT !== 1'b0 || overrunOUT !== 1'b0) begin errors++; $display("FAIL ovr_read: ready %b ovr %b want 0/0", dataReadyOUT, overrunOUT); end
    endtask

    task automatic test_baud_tolerance();
        int m;
        // Alternating 15/17-clock bits.
        align();
        m = cyc;
        send_frame(8'h55, 15, 17, 1'b1);
        wait_cyc(m + SYNC_DLY + LAT);
        checks++; if (dataOUT !== 8'h55 || frameErrOUT !== 1'b0 || dataReadyOUT !== 1'b1) begin errors++; $display("FAIL baud_55_alt: data %h ferr %b ready %b want 55/0/1", dataOUT, frameErrOUT, dataReadyOUT); end
        do_read();
        // Uniform fast line.
        align();
        m = cyc;
        send_frame(8'hFF, 15, 15, 1'b1);
        wait_cyc(m + SYNC_DLY + LAT);
        checks++; if (dataOUT !== 8'hFF || frameErrOUT !== 1'b0 || dataReadyOUT !== 1'b1) begin errors++; $display("FAIL baud_ff_15: data %h ferr %b ready %b want ff/0/1", dataOUT, frameErrOUT, dataReadyOUT); end
        do_read();
        // Uniform slow line; left unread for the reset test.
        align();
        m = cyc;
        send_frame(8'hFF, 17, 17, 1'b1);
        wait_cyc(m + SYNC_DLY + LAT);
        checks++; if (dataOUT !== 8'hFF || frameErrOUT !== 1'b0 || dataReadyOUT !== 1'b1) begin errors++; $display("FAIL baud_ff_17: data %h ferr %b ready %b want ff/0/1", dataOUT, frameErrOUT, dataReadyOUT); end
    endtask

    task automatic test_reset_midframe();
        int m;
        align();
        m = cyc;
        fork
            send_frame(8'h96, 16, 16, 1'b1);
            begin
                wait_cyc(m + 70);
                checks++; if (stateDbgOUT !== ST_DATA) begin errors++; $display("FAIL mrst_in_data: state %0d want %0d", stateDbgOUT, ST_DATA); end
                nResetIN = 1'b0;
                #1;
                checks++; if (dataOUT !== 8'h00 || dataReadyOUT !== 1'b0 || nBusyOUT !== 1'b1 ||
                              stateDbgOUT !== ST_IDLE || overrunOUT !== 1'b0 || frameErrOUT !== 1'b0) begin
                    errors++;
                    $display("FAIL mrst_values: data %h ready %b nbusy %b state %0d ovr %b ferr %b want 00/0/1/0/0/0",
                             dataOUT, dataReadyOUT, nBusyOUT, stateDbgOUT, overrunOUT, frameErrOUT);
                end
            end
        join
        align();
        nResetIN = 1'b1;
        repeat (20) align();
        checks++; if (dataReadyOUT !== 1'b0 || nBusyOUT !== 1'b1) begin errors++; $display("FAIL mrst_after: ready %b nbusy %b want 0/1", dataReadyOUT, nBusyOUT); end
        align();
        m = cyc;
        send_frame(8'h69, 16, 16, 1'b1);
        wait_cyc(m + SYNC_DLY + LAT);
        checks++; if (dataOUT !== 8'h69 || dataReadyOUT !== 1'b1 || frameErrOUT !== 1'b0 || overrunOUT !== 1'b0) begin
            errors++;
            $display("FAIL mrst_next: data %h ready %b ferr %b ovr %b want 69/1/0/0", dataOUT, dataReadyOUT, frameErrOUT, overrunOUT);
        end
        do_read();
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_framing();
        test_overrun();
        test_baud_tolerance();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
